// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch unit: AXI4 read master feeding a PC/instruction FIFO
// Optional macro INST_PREFETCH_BURST_EN enables bursts up to the next 16-byte boundary.
module inst_prefetch #(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_OFFSET_WIDTH   = 28,
    parameter int          DEPTH            = 4,
    parameter logic [31:0] RESET_PC         = 32'h0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EXEC,
    input  logic                        STALL,
    input  logic                        FLUSH,
    input  logic [31:0]                 FLUSH_PC,
    output logic [31:0]                 I_PC,
    output logic [31:0]                 I_INST,
    output logic                        I_VALID,
    output logic                        MEM_WAIT,
    output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                    state, state_next;
    logic [31:0]               pc_mem   [DEPTH];
    logic [31:0]               inst_mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count, reserved, beats;
    logic [CW:0]               need;
    logic [31:0]               fpc;
    logic                      discard;
    logic [C_OFFSET_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic                      start, beat, wr_en, pop;
    logic                      unused_rresp;

    assign unused_rresp = ^M_AXI_RRESP;

    always_comb begin
`ifdef INST_PREFETCH_BURST_EN
        beats = CW'(3'd4 - {1'b0, fpc[3:2]});
`else
        beats = CW'(1);
`endif
    end

    // Slots already promised to an accepted request count as used.
    assign need  = {1'b0, count} + {1'b0, reserved} + {1'b0, beats};
    assign beat  = (state == DATA) && M_AXI_RVALID;
    assign wr_en = beat && !discard && !FLUSH;
    assign pop   = I_VALID && !STALL && !FLUSH;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: if (EXEC && !FLUSH && (need <= (CW+1)'(DEPTH))) begin
                state_next = ADDR;
                start      = 1'b1;
            end
            ADDR: if (M_AXI_ARREADY) state_next = DATA;
            DATA: if (M_AXI_RVALID && M_AXI_RLAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc      <= RESET_PC;
            count    <= '0;
            reserved <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            discard  <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
        end else begin
            if (start) begin
                ar_addr <= fpc[C_OFFSET_WIDTH-1:0];
                ar_len  <= 8'(beats - CW'(1));
            end
            if (FLUSH) begin
                fpc      <= {FLUSH_PC[31:2], 2'b00};
                count    <= '0;
                reserved <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Outstanding beats of the old request are drained but dropped.
                discard  <= (state == ADDR) ||
                            ((state == DATA) && !(M_AXI_RVALID && M_AXI_RLAST));
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    fpc    <= fpc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count    <= count + CW'(wr_en) - CW'(pop);
                reserved <= reserved + (start ? beats : '0) - CW'(wr_en);
                if (beat && M_AXI_RLAST) discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= fpc;
            inst_mem[wr_ptr] <= M_AXI_RDATA[31:0];
        end
    end

    assign I_VALID       = (count != '0);
    assign I_PC          = I_VALID ? pc_mem[rd_ptr] : 32'h0;
    assign I_INST        = I_VALID ? inst_mem[rd_ptr] : 32'h0;
    assign MEM_WAIT      = EXEC && !I_VALID;
    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARLEN   = ar_len;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = (state == ADDR);
    assign M_AXI_RREADY  = (state == DATA);
endmodule
